// File: rtl/recv_m_1ofn_bridge.sv
// Receives an asynchronous e1ofN four-phase channel, synchronizes every rail,
// and hands each decoded codeword to a synchronous valid/ready consumer.
module recv_m_1ofn_bridge #(
    parameter  int M = 9,
    parameter  int N = 2,
    localparam int LN = $clog2(N),
    localparam int W  = M * LN
) (
    input  logic           CLK,
    input  logic           _RESET,
    input  logic [M*N-1:0] in_d,
    output logic           in_e,
    output logic [W-1:0]   rtl_data,
    output logic           rtl_valid,
    input  logic           rtl_ready,
    output logic           err
);

    typedef enum logic {IDLE, ACK} state_t;

    state_t         state_q, state_d;
    logic [M*N-1:0] sync1_q, sync2_q;
    logic [W-1:0]   data_q, data_d;
    logic           valid_q, valid_d;
    logic           err_q, err_d;

    logic [W-1:0]   dec_word;
    logic           cw_complete;
    logic           cw_neutral;
    logic           any_multi;
    logic           capture;

    // Stage 1/2: two-flop synchronizer on every rail; nothing else sees raw in_d.
    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= in_d;
            sync2_q <= sync1_q;
        end
    end

    // Per-digit completion check and one-hot to binary decode.
    always_comb begin
        dec_word    = '0;
        cw_complete = 1'b1;
        any_multi   = 1'b0;
        cw_neutral  = (sync2_q == '0);
        for (int i = 0; i < M; i++) begin
            if ($countones(sync2_q[i*N +: N]) != 1)
                cw_complete = 1'b0;
            if ($countones(sync2_q[i*N +: N]) > 1)
                any_multi = 1'b1;
            for (int r = 0; r < N; r++) begin
                if (sync2_q[i*N + r])
                    dec_word[i*LN +: LN] = dec_word[i*LN +: LN] | LN'(r);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                // Hold off while a word is parked in the buffer and not leaving now.
                if (cw_complete && (!valid_q || rtl_ready)) begin
                    capture = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                if (cw_neutral)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        data_d  = data_q;
        valid_d = valid_q;
        if (capture) begin
            data_d  = dec_word;
            valid_d = 1'b1;
        end else if (valid_q && rtl_ready) begin
            valid_d = 1'b0;
        end

        err_d = err_q | any_multi;
    end

    // Stage 3: handshake state, output buffer and sticky error.
    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            state_q <= IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign in_e      = (state_q == IDLE);
    assign rtl_data  = data_q;
    assign rtl_valid = valid_q;
    assign err       = err_q;

endmodule

// File: tb/tb_recv_m_1ofn_bridge.sv
// Scoreboard bench for recv_m_1ofn_bridge: directed handshake scenarios
// followed by a skewed four-phase sender with random consumer backpressure.
module tb_recv_m_1ofn_bridge;

    localparam int M = 9;
    localparam int N = 2;
    localparam int W = 9;

    logic           CLK;
    logic           rst_n;
    logic [M*N-1:0] in_d;
    logic           in_e;
    logic [W-1:0]   rtl_data;
    logic           rtl_valid;
    logic           rtl_ready;
    logic           err;

    logic           ready_dir;
    logic           ready_rnd;
    logic           rand_mode;

    int             checks;
    int             fails;
    logic [W-1:0]   sb_q[$];

    assign rtl_ready = rand_mode ? ready_rnd : ready_dir;

    recv_m_1ofn_bridge #(.M(M), .N(N)) dut (
        .CLK      (CLK),
        ._RESET   (rst_n),
        .in_d     (in_d),
        .in_e     (in_e),
        .rtl_data (rtl_data),
        .rtl_valid(rtl_valid),
        .rtl_ready(rtl_ready),
        .err      (err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        ready_rnd = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            ready_rnd = 1'($urandom_range(0, 1));
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every transfer seen by the consumer is matched against the scoreboard.
    always @(negedge CLK) begin
        if (rst_n && rtl_valid && rtl_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected word: got %0h, expected none", rtl_data);
            end else begin
                chk("scoreboard data", 32'(rtl_data), 32'(sb_q.pop_front()));
            end
        end
    end

    function automatic logic [M*N-1:0] enc(input logic [W-1:0] w);
        logic [M*N-1:0] r;
        r = '0;
        for (int i = 0; i < M; i++)
            r[i*N + int'(w[i])] = 1'b1;
        return r;
    endfunction

    task automatic edges(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_ine(input logic v, input string name);
        for (int i = 0; i < 300 && in_e !== v; i++)
            edges(1);
        chk(name, 32'(in_e), 32'(v));
    endtask

    task automatic drive_skew(input logic [M*N-1:0] target);
        int dly[M*N];
        for (int r = 0; r < M*N; r++)
            dly[r] = $urandom_range(0, 2);
        for (int k = 0; k < 3; k++) begin
            for (int r = 0; r < M*N; r++)
                if (dly[r] <= k)
                    in_d[r] = target[r];
            edges(1);
        end
    endtask

    initial begin
        logic [W-1:0] w;
        checks    = 0;
        fails     = 0;
        rand_mode = 1'b0;
        ready_dir = 1'b1;
        in_d      = '0;
        rst_n     = 1'b0;
        #1;
        chk("reset in_e", 32'(in_e), 32'd1);
        chk("reset rtl_valid", 32'(rtl_valid), 32'd0);
        chk("reset rtl_data", 32'(rtl_data), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        edges(2);
        rst_n = 1'b1;
        edges(2);

        // Basic word with consumer always ready: three-edge latency both ways.
        sb_q.push_back(9'h1A5);
        in_d = enc(9'h1A5);
        edges(2);
        chk("1A5 valid before edge 3", 32'(rtl_valid), 32'd0);
        edges(1);
        chk("1A5 valid on edge 3", 32'(rtl_valid), 32'd1);
        chk("1A5 in_e on edge 3", 32'(in_e), 32'd0);
        edges(1);
        in_d = '0;
        edges(2);
        chk("neutral in_e before edge 3", 32'(in_e), 32'd0);
        edges(1);
        chk("neutral in_e on edge 3", 32'(in_e), 32'd1);

        // Backpressure: parked word blocks the next capture until drained.
        ready_dir = 1'b0;
        sb_q.push_back(9'h0FF);
        in_d = enc(9'h0FF);
        edges(3);
        chk("0FF captured", 32'(rtl_valid), 32'd1);
        chk("0FF in_e", 32'(in_e), 32'd0);
        edges(5);
        chk("0FF held data", 32'(rtl_data), 32'h0FF);
        chk("0FF held valid", 32'(rtl_valid), 32'd1);
        in_d = '0;
        edges(3);
        chk("bp neutral in_e", 32'(in_e), 32'd1);
        sb_q.push_back(9'h100);
        in_d = enc(9'h100);
        edges(5);
        chk("100 blocked in_e", 32'(in_e), 32'd1);
        chk("100 blocked data", 32'(rtl_data), 32'h0FF);
        ready_dir = 1'b1;
        edges(1);
        chk("100 captured on drain edge", 32'(rtl_data), 32'h100);
        chk("100 valid on drain edge", 32'(rtl_valid), 32'd1);
        chk("100 in_e on drain edge", 32'(in_e), 32'd0);
        in_d = '0;
        wait_ine(1'b1, "bp final in_e");

        // Partial codeword never captures.
        in_d = enc(9'h1AB) & ~(18'h3 << 16);
        edges(20);
        chk("partial valid", 32'(rtl_valid), 32'd0);
        chk("partial in_e", 32'(in_e), 32'd1);
        sb_q.push_back(9'h1AB);
        in_d = enc(9'h1AB);
        edges(2);
        chk("9th digit valid before edge 3", 32'(rtl_valid), 32'd0);
        edges(1);
        chk("9th digit valid on edge 3", 32'(rtl_valid), 32'd1);
        in_d = '0;
        wait_ine(1'b1, "partial final in_e");

        // Illegal digit: both rails of digit 3.
        in_d = enc(9'h000) | (18'h3 << 6);
        edges(3);
        chk("illegal err", 32'(err), 32'd1);
        chk("illegal valid", 32'(rtl_valid), 32'd0);
        chk("illegal in_e", 32'(in_e), 32'd1);
        in_d = '0;
        edges(3);
        chk("err sticky", 32'(err), 32'd1);

        // Reset while in ACK with a parked word.
        ready_dir = 1'b0;
        in_d = enc(9'h055);
        edges(3);
        chk("pre-reset valid", 32'(rtl_valid), 32'd1);
        chk("pre-reset in_e", 32'(in_e), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset valid", 32'(rtl_valid), 32'd0);
        chk("async reset data", 32'(rtl_data), 32'd0);
        chk("async reset in_e", 32'(in_e), 32'd1);
        chk("async reset err", 32'(err), 32'd0);
        @(negedge CLK);
        #1;
        rst_n = 1'b1;
        sb_q.push_back(9'h055);
        edges(3);
        chk("recapture valid", 32'(rtl_valid), 32'd1);
        chk("recapture data", 32'(rtl_data), 32'h055);
        ready_dir = 1'b1;
        edges(1);
        in_d = '0;
        wait_ine(1'b1, "post-reset in_e");

        // Randomized skewed four-phase sender against random backpressure.
        rand_mode = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            wait_ine(1'b1, "rand in_e high");
            w = 9'($urandom);
            sb_q.push_back(w);
            drive_skew(enc(w));
            wait_ine(1'b0, "rand in_e low");
            drive_skew('0);
        end
        wait_ine(1'b1, "rand final in_e");
        for (int i = 0; i < 200 && sb_q.size() != 0; i++)
            edges(1);
        chk("scoreboard drained", 32'(sb_q.size()), 32'd0);
        chk("rand err clear", 32'(err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/recv_m_1ofn_bridge.md
RECV_M_1OFN_BRIDGE -- requirements
Module: recv_m_1ofn_bridge

Interface
REQ-001 Parameter M, default 9: number of 1-of-N digits in the channel.
REQ-002 Parameter N, default 2: rails per digit; power of two, N >= 2.
REQ-003 Derived constant W = M*log2(N), default 9: RTL data width, not user-overridable.
REQ-004 CLK  input  1  single system clock; all flops rising-edge.
REQ-005 _RESET  input  1  asynchronous, active-low reset.
REQ-006 in_d  input  M*N  asynchronous e1ofN data rails; digit i occupies in_d[i*N +: N]; rail r high encodes digit value r.
REQ-007 in_e  output  1  channel enable; 1 = ready for a codeword, 0 = acknowledge (codeword taken).
REQ-008 rtl_data  output  W  decoded word; digit i maps to rtl_data[i*log2(N) +: log2(N)], digit 0 least significant.
REQ-009 rtl_valid  output  1  rtl_data holds an undelivered word.
REQ-010 rtl_ready  input  1  RTL consumer accepts the word on any edge where rtl_valid & rtl_ready.
REQ-011 err  output  1  sticky flag; a digit had more than one rail high.

Function
REQ-012 Every in_d rail SHALL pass through a 2-flop synchronizer before any use; no logic reads raw in_d.
REQ-013 A digit is complete when exactly one synchronized rail is high; a codeword is complete when all M digits are complete.
REQ-014 A codeword is neutral when all M*N synchronized rails are low.
REQ-015 Handshake states: IDLE (in_e=1) and ACK (in_e=0).
REQ-016 IDLE -> ACK on the first edge where the codeword is complete and the output buffer is empty or being drained that same edge (rtl_valid & rtl_ready).
  - Same edge: capture the decoded word into rtl_data and set rtl_valid=1.
REQ-017 In IDLE with a complete codeword and a full, non-draining buffer: no capture, in_e stays 1, rails remain held by the sender.
REQ-018 ACK -> IDLE on the first edge where the codeword is neutral; in_e returns to 1.
  - No capture occurs in ACK.
REQ-019 Partial codewords (some digits with zero rails high) SHALL never be captured.
REQ-020 Decode: digit value = index of its single high rail, encoded in log2(N) binary bits.
REQ-021 Any digit with two or more rails high SHALL set err=1.
  - That codeword is not complete and is not captured.
  - err stays 1 until reset.
REQ-022 rtl_data and rtl_valid SHALL remain stable while rtl_valid=1 and rtl_ready=0.
  - rtl_valid clears on the accepting edge unless a new capture occurs on that same edge.
REQ-023 Latency from all rails valid at in_d to rtl_valid=1 and in_e=0: 3 rising edges (2 synchronizer + 1 capture).
REQ-024 Throughput: at most one word per four-phase cycle; rtl_ready may be held high permanently without loss or duplication.

Reset
REQ-025 On _RESET=0, asynchronously and regardless of state:
  - all synchronizer flops = 0, state = IDLE, in_e = 1;
  - rtl_valid = 0, rtl_data = 0, err = 0.
REQ-026 Reset mid-handshake (ACK or buffer full) SHALL discard the pending word.
  - After release, operation restarts from IDLE; a codeword still held on in_d is captured normally once synchronized.

Verification
REQ-027 M=9, N=2, rtl_ready=1:
  - drive codeword for 9'h1A5 -> rtl_valid=1 and rtl_data=9'h1A5 on the 3rd edge, in_e=0 on the same edge;
  - drop rails to neutral -> in_e=1 three edges later.
REQ-028 Backpressure, rtl_ready=0:
  - word 9'h0FF captured and held; in_e=0;
  - after neutral, in_e=1; next word 9'h100 presented and not captured (in_e stays 1);
  - raise rtl_ready -> 9'h0FF delivered, 9'h100 captured on the same edge, no word lost.
REQ-029 Partial codeword: 8 of 9 digits driven for 20 cycles -> rtl_valid=0, in_e=1; drive 9th digit -> capture 3 edges later.
REQ-030 Illegal digit (digit 3 with both rails high) -> err=1, no capture, in_e=1; err remains 1 after rails return to neutral.
REQ-031 Assert _RESET in ACK state with rtl_valid=1 -> immediately rtl_valid=0, rtl_data=0, in_e=1, err=0.
REQ-032 Randomized 1000-word four-phase sender with random rtl_ready and random per-rail skew up to 2 cycles -> received sequence equals sent sequence; err never set.
